// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, alu and response signals around alu_arbiter.
// slave is the arbiter's view; master is the requesters/alu/consumer side.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_op1;
  logic [DATA_W-1:0] req0_op2;
  logic [OP_W-1:0]   req0_alu_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_op1;
  logic [DATA_W-1:0] req1_op2;
  logic [OP_W-1:0]   req1_alu_op;

  logic [DATA_W-1:0] alu_op1;
  logic [DATA_W-1:0] alu_op2;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              busy;

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_alu_op,
    output req0_ready,
    input  req1_valid, req1_op1, req1_op2, req1_alu_op,
    output req1_ready,
    output alu_op1, alu_op2, alu_op,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_zero,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_alu_op,
    input  req0_ready,
    output req1_valid, req1_op1, req1_op2, req1_alu_op,
    input  req1_ready,
    input  alu_op1, alu_op2, alu_op,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational alu between two requesters.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt0/1).
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
`ifdef ALU_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  , output logic [CNT_W-1:0] grant_cnt0
  , output logic [CNT_W-1:0] grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic              id;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [OP_W-1:0]   op_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_zero_q;

  logic              winner;
  logic              win_valid;
  logic              take;

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    win_valid = bus.req0_valid | bus.req1_valid;
    winner    = 1'b0;
    if (bus.req0_valid & bus.req1_valid)
      winner = ~last_grant;
    else if (bus.req1_valid)
      winner = 1'b1;
  end

  assign take           = (state == IDLE) & win_valid & ~rst;
  assign bus.req0_ready = take & ~winner;
  assign bus.req1_ready = take & winner;

  assign bus.alu_op1    = op1_q;
  assign bus.alu_op2    = op2_q;
  assign bus.alu_op     = op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      id           <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            op1_q      <= winner ? bus.req1_op1    : bus.req0_op1;
            op2_q      <= winner ? bus.req1_op2    : bus.req0_op2;
            op_q       <= winner ? bus.req1_alu_op : bus.req0_alu_op;
            id         <= winner;
            last_grant <= winner;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= bus.alu_result;
          rsp_zero_q   <= bus.alu_zero;
          rsp_id_q     <= id;
          rsp_valid_q  <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          // rsp_valid is always high here, so rsp_ready alone completes the transfer.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (take & ~winner & (grant_cnt0 != '1))
        grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (take & winner & (grant_cnt1 != '1))
        grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus random traffic against a transaction-level model
// of alu_arbiter; the bench also plays the role of the combinational alu.
module tb_alu_arbiter;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

`ifdef ALU_ARB_STATS_EN
  localparam int CNT_W = 2;
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;
  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1));
`else
  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a;
    endcase
  endfunction

  assign bus.alu_result = aluRef(bus.alu_op, bus.alu_op1, bus.alu_op2);
  assign bus.alu_zero   = (bus.alu_result == 32'd0);

  int test_count = 0;
  int fail_count = 0;

  logic [31:0] req_a  [2];
  logic [31:0] req_b  [2];
  logic [3:0]  req_op [2];
  bit          req_v  [2];
  bit          rsp_ready_drv;

  // Transaction-level model: one op in flight, response visible two cycles after its handshake.
  int          cyc;
  int          hs_cycle;
  bit          pending;
  int          last_grant_m;
  logic [31:0] exp_a1, exp_a2, exp_res;
  logic [3:0]  exp_op;
  bit          exp_id;
  bit          acc [2];
  int          cnt [2];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic driveReqs();
    bus.req0_valid  = req_v[0];
    bus.req0_op1    = req_a[0];
    bus.req0_op2    = req_b[0];
    bus.req0_alu_op = req_op[0];
    bus.req1_valid  = req_v[1];
    bus.req1_op1    = req_a[1];
    bus.req1_op2    = req_b[1];
    bus.req1_alu_op = req_op[1];
    bus.rsp_ready   = rsp_ready_drv;
  endtask

  task automatic setReq(input int n, input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
    req_v[n]  = v;
    req_a[n]  = a;
    req_b[n]  = b;
    req_op[n] = op;
    driveReqs();
  endtask

  function automatic void modelReset();
    pending      = 1'b0;
    last_grant_m = 1;
    exp_a1       = '0;
    exp_a2       = '0;
    exp_op       = '0;
    acc[0]       = 1'b0;
    acc[1]       = 1'b0;
    cnt[0]       = 0;
    cnt[1]       = 0;
  endfunction

  function automatic logic [31:0] satCnt(input int c);
`ifdef ALU_ARB_STATS_EN
    int top;
    top = (1 << CNT_W) - 1;
    return (c > top) ? 32'(top) : 32'(c);
`else
    return 32'(c);
`endif
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Compare all observable outputs at the falling edge, then step the model by one cycle.
  task automatic sampleCycle();
    int win;
    bit exp_rsp_valid, exp_busy;
    @(negedge clk);
    win = -1;
    if (!pending && !rst) begin
      if (req_v[0] && req_v[1]) win = 1 - last_grant_m;
      else if (req_v[0])        win = 0;
      else if (req_v[1])        win = 1;
    end
    exp_busy      = pending && (cyc > hs_cycle);
    exp_rsp_valid = pending && (cyc >= hs_cycle + 2);
    checkOutput("req0_ready", bus.req0_ready, {31'b0, win == 0});
    checkOutput("req1_ready", bus.req1_ready, {31'b0, win == 1});
    checkOutput("busy", bus.busy, {31'b0, exp_busy});
    checkOutput("rsp_valid", bus.rsp_valid, {31'b0, exp_rsp_valid});
    if (exp_rsp_valid) begin
      checkOutput("rsp_id", bus.rsp_id, {31'b0, exp_id});
      checkOutput("rsp_result", bus.rsp_result, exp_res);
      checkOutput("rsp_zero", bus.rsp_zero, {31'b0, exp_res == 32'd0});
    end
    checkOutput("alu_op1", bus.alu_op1, exp_a1);
    checkOutput("alu_op2", bus.alu_op2, exp_a2);
    checkOutput("alu_op", bus.alu_op, {28'b0, exp_op});
`ifdef ALU_ARB_STATS_EN
    checkOutput("grant_cnt0", grant_cnt0, satCnt(cnt[0]));
    checkOutput("grant_cnt1", grant_cnt1, satCnt(cnt[1]));
`endif
    acc[0] = (win == 0);
    acc[1] = (win == 1);
    if (rst) begin
      modelReset();
    end else begin
      if (exp_rsp_valid && rsp_ready_drv) pending = 1'b0;
      if (win >= 0) begin
        pending      = 1'b1;
        hs_cycle     = cyc;
        last_grant_m = win;
        exp_id       = (win == 1);
        exp_a1       = req_a[win];
        exp_a2       = req_b[win];
        exp_op       = req_op[win];
        exp_res      = aluRef(exp_op, exp_a1, exp_a2);
        cnt[win]++;
      end
    end
    cyc++;
  endtask

  task automatic doReset();
    rst = 1'b1;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    driveReqs();
    sampleCycle();
    advance();
    rst = 1'b0;
  endtask

  // Random traffic that honours the hold rule: a waiting request keeps its fields or drops valid.
  task automatic applyStimulus();
    for (int n = 0; n < 2; n++) begin
      if (req_v[n] && !acc[n]) begin
        if ($urandom_range(0, 7) == 0) req_v[n] = 1'b0;
      end else begin
        req_v[n]  = ($urandom_range(0, 3) != 0);
        req_a[n]  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        req_b[n]  = ($urandom_range(0, 3) == 0) ? req_a[n] : $urandom;
        req_op[n] = 4'($urandom_range(0, 5));
      end
    end
    rsp_ready_drv = ($urandom_range(0, 3) != 0);
    driveReqs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ids[$];
    bit seen;
    cyc      = 0;
    hs_cycle = 0;
    exp_res  = '0;
    exp_id   = 1'b0;
    rsp_ready_drv = 1'b0;
    for (int n = 0; n < 2; n++) begin
      req_v[n] = 1'b0; req_a[n] = '0; req_b[n] = '0; req_op[n] = '0;
    end
    driveReqs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();

    sampleCycle();
    checkOutput("rst_rsp_id", bus.rsp_id, 0);
    checkOutput("rst_rsp_result", bus.rsp_result, 0);
    checkOutput("rst_rsp_zero", bus.rsp_zero, 0);
    advance();

    $display("[TB] single op");
    rsp_ready_drv = 1'b1;
    setReq(0, 1'b1, 32'd5, 32'd3, OP_ADD);
    sampleCycle();
    checkOutput("single_ready0", bus.req0_ready, 1);
    advance();
    setReq(0, 1'b0, 32'd5, 32'd3, OP_ADD);
    sampleCycle();
    checkOutput("single_busy_n1", bus.busy, 1);
    checkOutput("single_no_rsp_n1", bus.rsp_valid, 0);
    advance();
    sampleCycle();
    checkOutput("single_rsp_valid", bus.rsp_valid, 1);
    checkOutput("single_result", bus.rsp_result, 32'd8);
    checkOutput("single_id", bus.rsp_id, 0);
    checkOutput("single_zero", bus.rsp_zero, 0);
    checkOutput("single_busy_n2", bus.busy, 1);
    advance();
    sampleCycle();
    checkOutput("single_idle", bus.busy, 0);
    advance();

    $display("[TB] tie alternation");
    doReset();
    rsp_ready_drv = 1'b1;
    setReq(0, 1'b1, 32'd10, 32'd20, OP_ADD);
    setReq(1, 1'b1, 32'd7, 32'd7, OP_SUB);
    repeat (12) begin
      sampleCycle();
      if (bus.rsp_valid === 1'b1) begin
        ids.push_back(bus.rsp_id);
        if (bus.rsp_id === 1'b1) begin
          checkOutput("tie_sub_result", bus.rsp_result, 0);
          checkOutput("tie_sub_zero", bus.rsp_zero, 1);
        end else begin
          checkOutput("tie_add_result", bus.rsp_result, 32'd30);
        end
      end
      advance();
    end
    checkOutput("tie_count", ids.size(), 4);
    for (int i = 0; i < ids.size() && i < 4; i++)
      checkOutput("tie_order", {31'b0, ids[i]}, i % 2);

    $display("[TB] backpressure");
    doReset();
    rsp_ready_drv = 1'b0;
    setReq(0, 1'b1, 32'd1, 32'd2, OP_ADD);
    setReq(1, 1'b1, 32'hF0, 32'h0F, OP_XOR);
    sampleCycle();
    advance();
    setReq(0, 1'b0, 32'd1, 32'd2, OP_ADD);
    sampleCycle();
    advance();
    repeat (5) begin
      sampleCycle();
      checkOutput("bp_rsp_valid", bus.rsp_valid, 1);
      checkOutput("bp_result", bus.rsp_result, 32'd3);
      checkOutput("bp_ready0", bus.req0_ready, 0);
      checkOutput("bp_ready1", bus.req1_ready, 0);
      advance();
    end
    rsp_ready_drv = 1'b1;
    driveReqs();
    sampleCycle();
    advance();
    sampleCycle();
    checkOutput("bp_next_grant", bus.req1_ready, 1);
    advance();
    setReq(1, 1'b0, 32'hF0, 32'h0F, OP_XOR);
    repeat (3) begin
      sampleCycle();
      advance();
    end

    $display("[TB] negative operand");
    seen = 1'b0;
    setReq(1, 1'b1, 32'hFFFF_FFFE, 32'd1, OP_ADD);
    repeat (5) begin
      sampleCycle();
      if (bus.rsp_valid === 1'b1) begin
        seen = 1'b1;
        checkOutput("neg_result", bus.rsp_result, 32'hFFFF_FFFF);
        checkOutput("neg_id", bus.rsp_id, 1);
      end
      advance();
      if (acc[1]) setReq(1, 1'b0, 32'hFFFF_FFFE, 32'd1, OP_ADD);
    end
    checkOutput("neg_seen", {31'b0, seen}, 1);

    $display("[TB] reset during exec");
    setReq(0, 1'b1, 32'd9, 32'd9, OP_SUB);
    sampleCycle();
    advance();
    rst = 1'b1;
    setReq(0, 1'b0, 32'd9, 32'd9, OP_SUB);
    sampleCycle();
    advance();
    rst = 1'b0;
    repeat (3) begin
      sampleCycle();
      checkOutput("rst_exec_rsp_valid", bus.rsp_valid, 0);
      checkOutput("rst_exec_result", bus.rsp_result, 0);
      checkOutput("rst_exec_zero", bus.rsp_zero, 0);
      checkOutput("rst_exec_alu_op1", bus.alu_op1, 0);
      advance();
    end
    setReq(0, 1'b1, 32'd4, 32'd4, OP_AND);
    setReq(1, 1'b1, 32'd6, 32'd1, OP_OR);
    sampleCycle();
    checkOutput("rst_tie_ready0", bus.req0_ready, 1);
    advance();

    $display("[TB] random traffic");
    repeat (800) begin
      applyStimulus();
      sampleCycle();
      advance();
    end

`ifdef ALU_ARB_STATS_EN
    $display("[TB] stats saturation");
    doReset();
    rsp_ready_drv = 1'b1;
    setReq(1, 1'b0, 32'd0, 32'd0, OP_ADD);
    setReq(0, 1'b1, 32'd2, 32'd2, OP_ADD);
    repeat (14) begin
      sampleCycle();
      advance();
    end
    setReq(0, 1'b0, 32'd2, 32'd2, OP_ADD);
    repeat (3) begin
      sampleCycle();
      advance();
    end
    checkOutput("stats_cnt0", grant_cnt0, 3);
    checkOutput("stats_cnt1", grant_cnt1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
